// File: rtl/hist_eq_stream.sv
// Streaming histogram equaliser. Each frame is mapped through the LUT built
// from the previous frame while the current frame's histogram accumulates.
// The first frame after reset passes through unchanged.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_CLEAR | zero every histogram bin, one per cycle (after reset only)
// S_IDLE  | wait for enable before accepting a frame
// S_ACCUM | accept pixels, map them, count them into the histogram
// S_DRAIN | wait for the accumulate and output pipelines to empty
// S_CDF   | cumulative pass: build shadow LUT, clear bins, swap banks
module hist_eq_stream #(
    parameter int DW      = 8,
    parameter int PIX_CNT = 160000,
    parameter int CNT_W   = 18,
    parameter int FRAC    = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          lut_valid,
    output logic          frame_done,
    output logic          frame_err
);

    localparam int DEPTH = 1 << DW;
    localparam int PW    = CNT_W + FRAC + 1;
    localparam longint SCALE = (longint'(DEPTH - 1) << FRAC) / longint'(PIX_CNT);
    localparam logic [PW-1:0]    SCALE_V   = PW'(SCALE);
    localparam logic [PW-1:0]    LUT_MAX_W = PW'(DEPTH - 1);
    localparam logic [DW-1:0]    PIX_MAX   = '1;
    localparam logic [CNT_W-1:0] BIN_MAX   = '1;
    localparam logic [CNT_W-1:0] BIN_ONE   = 1;
    localparam logic [CNT_W:0]   CNT_MAX   = '1;
    localparam logic [CNT_W:0]   CNT_ONE   = 1;
    localparam logic [CNT_W:0]   PIX_CNT_V = (CNT_W + 1)'(PIX_CNT);
    localparam logic [DW:0]      IDX_ONE   = 1;

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_ACCUM, S_DRAIN, S_CDF} state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] hist [DEPTH];
    logic [DW-1:0]    lut  [2][DEPTH];
    logic             lut_sel;

    logic [DW:0]      idx;
    logic [DW-1:0]    idx_a;
    logic             accept, adv, cdf_issue, cdf_end;

    logic             acc_v;
    logic [DW-1:0]    acc_a;
    logic             wb_v;
    logic [DW-1:0]    wb_a;
    logic [CNT_W-1:0] wb_d;
    logic [CNT_W-1:0] rd_q, acc_cur, acc_new;
    logic [DW-1:0]    rd_a;

    logic             hw_en;
    logic [DW-1:0]    hw_a;
    logic [CNT_W-1:0] hw_d;

    logic             c1_v;
    logic [DW-1:0]    c1_a;
    logic [CNT_W-1:0] sum, sum_n;
    logic [CNT_W:0]   sum_ext;
    logic [PW-1:0]    prod, shf;
    logic [DW-1:0]    lut_new;
    logic [CNT_W:0]   pix_cnt;

    logic             m1_v, m1_l;
    logic [DW-1:0]    m1_d;

    assign idx_a     = idx[DW-1:0];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = (state == S_ACCUM) && adv;
    assign accept    = in_valid && in_ready;
    assign cdf_issue = (state == S_CDF) && !idx[DW];
    assign cdf_end   = (state == S_CDF) && idx[DW];
    assign rd_a      = (state == S_CDF) ? idx_a : in_data;

    // Forward the write that lands on the same edge as this pixel's read.
    assign acc_cur = (wb_v && (wb_a == acc_a)) ? wb_d : rd_q;
    assign acc_new = (acc_cur == BIN_MAX) ? acc_cur : acc_cur + BIN_ONE;

    assign sum_ext = {1'b0, sum} + {1'b0, rd_q};
    assign sum_n   = sum_ext[CNT_W] ? BIN_MAX : sum_ext[CNT_W-1:0];
    assign prod    = PW'(sum_n) * SCALE_V;
    assign shf     = prod >> FRAC;
    assign lut_new = (shf > LUT_MAX_W) ? PIX_MAX : shf[DW-1:0];

    // Next-state decode; enable only matters at frame boundaries.
    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (idx_a == PIX_MAX) state_nxt = S_IDLE;
            S_IDLE:  if (enable) state_nxt = S_ACCUM;
            S_ACCUM: if (accept && in_last) state_nxt = S_DRAIN;
            S_DRAIN: if (!acc_v && !m1_v && !out_valid) state_nxt = S_CDF;
            S_CDF:   if (idx[DW]) state_nxt = enable ? S_ACCUM : S_IDLE;
            default: state_nxt = S_CLEAR;
        endcase
    end

    // Histogram write port: bin clears win over accumulation (never concurrent).
    always_comb begin
        hw_en = 1'b0;
        hw_a  = idx_a;
        hw_d  = '0;
        if ((state == S_CLEAR) || cdf_issue) begin
            hw_en = 1'b1;
        end else if (acc_v) begin
            hw_en = 1'b1;
            hw_a  = acc_a;
            hw_d  = acc_new;
        end
    end

    // Histogram and LUT storage; read-old-data on a shared address.
    always_ff @(posedge clk) begin
        rd_q <= hist[rd_a];
        if (hw_en) hist[hw_a] <= hw_d;
        if (c1_v) lut[~lut_sel][c1_a] <= lut_new;
    end

    // State, address counter, accumulate/CDF pipelines and frame status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_CLEAR;
            idx        <= '0;
            acc_v      <= 1'b0;
            acc_a      <= '0;
            wb_v       <= 1'b0;
            wb_a       <= '0;
            wb_d       <= '0;
            c1_v       <= 1'b0;
            c1_a       <= '0;
            sum        <= '0;
            pix_cnt    <= '0;
            lut_sel    <= 1'b0;
            lut_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                idx <= '0;
            else if ((state == S_CLEAR) || (state == S_CDF))
                idx <= idx + IDX_ONE;
            else
                idx <= '0;

            acc_v <= accept;
            acc_a <= in_data;
            wb_v  <= acc_v;
            wb_a  <= acc_a;
            wb_d  <= acc_new;

            c1_v <= cdf_issue;
            c1_a <= idx_a;

            if (cdf_end) begin
                sum     <= '0;
                pix_cnt <= '0;
            end else begin
                if (c1_v) sum <= sum_n;
                if (accept && (pix_cnt != CNT_MAX)) pix_cnt <= pix_cnt + CNT_ONE;
            end

            frame_done <= cdf_end;
            frame_err  <= cdf_end && (pix_cnt != PIX_CNT_V);
            if (cdf_end) begin
                lut_sel   <= ~lut_sel;
                lut_valid <= 1'b1;
            end
        end
    end

    // Two-stage map pipeline that advances only when the output can move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_v      <= 1'b0;
            m1_d      <= '0;
            m1_l      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            m1_v      <= accept;
            m1_d      <= in_data;
            m1_l      <= in_last;
            out_valid <= m1_v;
            if (m1_v) begin
                out_data <= lut_valid ? lut[lut_sel][m1_d] : m1_d;
                out_last <= m1_l;
            end
        end
    end

endmodule
